cpu_bus_if: RTL and testbench
=============================

# cpu_bus_if

Memory-stage bus interface for the pipelined CPU: the responder to the decoder's `mem_op`/address/write-data outputs once they reach the MEM stage. Word accesses to the scratch-pad memory (SPM) complete in a single cycle. All other accesses run an arbitrated request/grant/strobe/ready transaction on the shared system bus, and the pipeline is stalled through `busy` until the transaction finishes.

## Interface
Parameters:
- `SPM_PAGE`, default 3'h3: value of `addr[29:27]` that selects the SPM.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `stall`  in  1  pipeline stall from the CPU control unit.
- `flush`  in  1  pipeline flush; suppresses starting a new access.
- `mem_op`  in  2  access request: `MEM_OP_NOP`=0, `MEM_OP_LDW`=1, `MEM_OP_STW`=2; value 3 is treated as NOP.
- `addr`  in  30  word address.
- `wr_data`  in  32  store data.
- `rd_data`  out  32  load data returned to the MEM stage.
- `busy`  out  1  bus access in progress; the CPU must stall.
- `spm_rd_data`  in  32  SPM read data, combinational from the SPM port.
- `spm_addr`  out  30  equals `addr`.
- `spm_as_`  out  1  SPM strobe, active-low.
- `spm_rw`  out  1  READ=1, WRITE=0.
- `spm_wr_data`  out  32  equals `wr_data`.
- `bus_req_`  out  1  bus request to the arbiter, active-low.
- `bus_grnt_`  in  1  grant, active-low.
- `bus_addr`  out  30  registered bus address.
- `bus_as_`  out  1  bus strobe, active-low.
- `bus_rw`  out  1  READ=1, WRITE=0; registered.
- `bus_wr_data`  out  32  registered store data.
- `bus_rdy_`  in  1  slave ready, active-low.
- `bus_rd_data`  in  32  slave read data, valid while `bus_rdy_`=0.

## Operation
- The block has four states: IDLE=0, REQ=1, ACCESS=2, STALL=3.
- A request is active when `mem_op` is LDW or STW and `flush`=0.
- Behaviour in IDLE:
  - Active request with `addr[29:27]==SPM_PAGE`: `spm_as_`=0 combinationally, `spm_rw` is driven from `mem_op`, `rd_data`=`spm_rd_data`, and `busy`=0. The state stays IDLE.
  - Active request to any other address: `busy`=1 combinationally. Register `bus_addr`, `bus_rw`, `bus_wr_data`, set `bus_req_`<=0, and go to REQ.
  - No active request: `rd_data`=0 and `busy`=0.
- REQ: `busy`=1. When `bus_grnt_`=0, set `bus_as_`<=0 and go to ACCESS.
- ACCESS:
  - `bus_as_` is low only in the first ACCESS cycle; it is registered back to 1 on the next edge.
  - While `bus_rdy_`=1: `busy`=1.
  - When `bus_rdy_`=0: `busy`=0 and `rd_data`=`bus_rd_data` combinationally; `rd_buf`<=`bus_rd_data`; `bus_req_`<=1. Next state is STALL if `stall`=1, otherwise IDLE.
- STALL: `busy`=0 and `rd_data`=`rd_buf`. Go to IDLE when `stall`=0.
- `flush` affects IDLE only. A bus transaction already in REQ or ACCESS always completes.
- `bus_rdy_` is ignored outside ACCESS. `bus_grnt_` is ignored outside REQ.
- For store accesses, `rd_data` is undefined; the pipeline discards it.

## Timing
- Reset values:
  - state IDLE
  - `bus_req_`=1, `bus_as_`=1, `bus_rw`=READ
  - `bus_addr`=0, `bus_wr_data`=0, `rd_buf`=0
  - `busy`=0, `rd_data`=0, `spm_as_`=1
- SPM access has zero added latency: data is returned in the same cycle and no stall is generated.
- Bus access, minimum case (grant immediate, ready in the first ACCESS cycle):
  - Cycle 0: IDLE, request accepted, `busy`=1.
  - Cycle 1: REQ, `bus_req_`=0, grant sampled, `busy`=1.
  - Cycle 2: ACCESS, `bus_as_`=0, `bus_rdy_`=0, `busy`=0, data returned.
  - Result: 2 stall cycles.
- Each cycle of grant delay or ready delay adds one `busy` cycle.
- A new access can be accepted in the cycle after ACCESS completes (back-to-back).
- Reset asserted mid-transaction forces IDLE on the next edge and releases `bus_req_`/`bus_as_`. The slave tolerates the abandoned strobe.

## Structure
- Shared package `cpu_pkg` holds:
  - `MEM_OP_*` and the `BUS_IF_STATE_*` enum
  - READ/WRITE encodings
  - active-low ENABLE_/DISABLE_ constants
  - SPM address field location
- A single module; a sub-module split is not natural. The state register, output registers and `rd_buf` all live in `cpu_bus_if`.

## Test plan
- SPM load: `mem_op`=LDW, `addr`=30'h1800_0004, `spm_rd_data`=32'hCAFE_0001 -> same cycle `spm_as_`=0, `rd_data`=32'hCAFE_0001, `busy`=0, bus pins idle.
- Bus load, immediate grant/ready: `addr`=30'h0000_0010, grant in REQ, `bus_rdy_`=0 with `bus_rd_data`=32'h1234_5678 in the first ACCESS cycle -> `busy`=1 for 2 cycles, then `rd_data`=32'h1234_5678 and `bus_req_` released.
- Bus store with 3-cycle grant delay and 2-cycle ready delay -> `bus_rw`=0, `bus_wr_data`=`wr_data`, `bus_as_` low exactly 1 cycle, `busy`=1 for 7 cycles.
- Load completing while `stall`=1 for 3 cycles -> state STALL, `rd_data` holds 32'h1234_5678 throughout, return to IDLE on the first cycle with `stall`=0.
- `flush`=1 with `mem_op`=STW to a bus address -> no `bus_req_`, `busy`=0. `flush` asserted during ACCESS -> transaction completes normally.
- `reset` asserted during REQ -> next cycle state IDLE, `bus_req_`=1, `bus_as_`=1, `rd_data`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU encodings for memory ops, bus-interface states and bus signal levels.
package cpu_pkg;
  localparam logic [1:0] MEM_OP_NOP = 2'd0;
  localparam logic [1:0] MEM_OP_LDW = 2'd1;
  localparam logic [1:0] MEM_OP_STW = 2'd2;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam int SPM_MSB = 29;
  localparam int SPM_LSB = 27;
  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE = 2'd0,
    BUS_IF_STATE_REQ = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_STALL = 2'd3
  } bus_if_state_e;
endpackage

// File: rtl/cpu_bus_if.sv
// cpu_bus_if: MEM-stage responder; single-cycle SPM word access, arbitrated system-bus access otherwise.
module cpu_bus_if
  import cpu_pkg::*;
#(
  parameter logic [2:0] SPM_PAGE = 3'h3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  mem_op,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  input  logic [31:0] spm_rd_data,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic        bus_rdy_,
  input  logic [31:0] bus_rd_data
);
  bus_if_state_e state_q, state_d;
  logic bus_req_q, bus_req_d, bus_as_q, bus_as_d, bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d, rd_buf_q, rd_buf_d;
  logic active, to_spm;
  assign active = !flush && (mem_op == MEM_OP_LDW || mem_op == MEM_OP_STW);
  assign to_spm = addr[SPM_MSB:SPM_LSB] == SPM_PAGE;
  assign spm_addr = addr;
  assign spm_wr_data = wr_data;
  assign bus_req_ = bus_req_q;
  assign bus_as_ = bus_as_q;
  assign bus_rw = bus_rw_q;
  assign bus_addr = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  always_comb begin
    state_d = state_q;
    bus_req_d = bus_req_q;
    bus_as_d = bus_as_q;
    bus_rw_d = bus_rw_q;
    bus_addr_d = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d = rd_buf_q;
    busy = 1'b0;
    rd_data = '0;
    spm_as_ = DISABLE_;
    spm_rw = READ;
    case (state_q)
      BUS_IF_STATE_IDLE: begin
        if (active && to_spm) begin
          spm_as_ = ENABLE_;
          spm_rw = (mem_op == MEM_OP_LDW) ? READ : WRITE;
          rd_data = spm_rd_data;
        end else if (active) begin
          busy = 1'b1;
          bus_addr_d = addr;
          bus_rw_d = (mem_op == MEM_OP_LDW) ? READ : WRITE;
          bus_wr_data_d = wr_data;
          bus_req_d = ENABLE_;
          state_d = BUS_IF_STATE_REQ;
        end
      end
      BUS_IF_STATE_REQ: begin
        busy = 1'b1;
        if (bus_grnt_ == ENABLE_) begin
          bus_as_d = ENABLE_;
          state_d = BUS_IF_STATE_ACCESS;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        // strobe is a one-cycle pulse at the start of ACCESS
        bus_as_d = DISABLE_;
        if (bus_rdy_ == ENABLE_) begin
          rd_data = bus_rd_data;
          rd_buf_d = bus_rd_data;
          bus_req_d = DISABLE_;
          state_d = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      BUS_IF_STATE_STALL: begin
        rd_data = rd_buf_q;
        if (!stall) state_d = BUS_IF_STATE_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_IF_STATE_IDLE;
      bus_req_q <= DISABLE_;
      bus_as_q <= DISABLE_;
      bus_rw_q <= READ;
      bus_addr_q <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q <= state_d;
      bus_req_q <= bus_req_d;
      bus_as_q <= bus_as_d;
      bus_rw_q <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q <= rd_buf_d;
    end
  end
endmodule

// File: tb/tb_cpu_bus_if.sv
// tb_cpu_bus_if: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_cpu_bus_if;
  logic clk = 1'b0;
  logic reset, stall, flush;
  logic [1:0] mem_op;
  logic [29:0] addr, spm_addr, bus_addr;
  logic [31:0] wr_data, rd_data, spm_rd_data, spm_wr_data, bus_wr_data, bus_rd_data;
  logic busy, spm_as_, spm_rw, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  int checks = 0;
  int errors = 0;

  cpu_bus_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_op(mem_op), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .spm_rd_data(spm_rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rdy_(bus_rdy_), .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; mem_op = 2'd0; addr = '0; wr_data = '0;
    spm_rd_data = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_data !== 32'h0 || spm_as_ !== 1'b1) begin
      errors++; $display("FAIL reset_outputs: busy=%b rd_data=%h spm_as_=%b required 0 0 1", busy, rd_data, spm_as_);
    end
    checks++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || bus_rw !== 1'b1) begin
      errors++; $display("FAIL reset_bus_ctl: req_=%b as_=%b rw=%b required 1 1 1", bus_req_, bus_as_, bus_rw);
    end
    checks++;
    if (bus_addr !== 30'h0 || bus_wr_data !== 32'h0) begin
      errors++; $display("FAIL reset_bus_regs: addr=%h wd=%h required 0 0", bus_addr, bus_wr_data);
    end
    @(negedge clk);
  endtask

  task automatic test_spm_load();
    mem_op = 2'd1; addr = 30'h1800_0004; spm_rd_data = 32'hCAFE_0001; wr_data = 32'h5555_AAAA;
    #1;
    checks++;
    if (spm_as_ !== 1'b0 || spm_rw !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL spm_load_ctl: spm_as_=%b spm_rw=%b busy=%b required 0 1 0", spm_as_, spm_rw, busy);
    end
    checks++;
    if (rd_data !== 32'hCAFE_0001) begin
      errors++; $display("FAIL spm_load_data: got %h required cafe0001", rd_data);
    end
    checks++;
    if (spm_addr !== 30'h1800_0004 || spm_wr_data !== 32'h5555_AAAA) begin
      errors++; $display("FAIL spm_passthru: addr=%h wd=%h required 18000004 5555aaaa", spm_addr, spm_wr_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL spm_bus_idle: req_=%b as_=%b busy=%b required 1 1 0", bus_req_, bus_as_, busy);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    mem_op = 2'd1; addr = 30'h0000_0010; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bus_load_c0_busy: got %b required 1", busy); end
    @(negedge clk);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h1234_5678;
    #1;
    checks++;
    if (busy !== 1'b1 || bus_req_ !== 1'b0 || bus_as_ !== 1'b1 || bus_addr !== 30'h10 || bus_rw !== 1'b1) begin
      errors++; $display("FAIL bus_load_req: busy=%b req_=%b as_=%b addr=%h rw=%b required 1 0 1 10 1",
                         busy, bus_req_, bus_as_, bus_addr, bus_rw);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_as_ !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL bus_load_access: as_=%b busy=%b rd_data=%h required 0 0 12345678", bus_as_, busy, rd_data);
    end
    @(negedge clk);
    addr = 30'h0000_0020; bus_rdy_ = 1'b1;
    #1;
    checks++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: req_=%b as_=%b busy=%b required 1 1 1", bus_req_, bus_as_, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_req_ !== 1'b0 || bus_addr !== 30'h20) begin
      errors++; $display("FAIL b2b_req: req_=%b addr=%h required 0 20", bus_req_, bus_addr);
    end
    @(negedge clk);
    bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_0002;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_data !== 32'hA5A5_0002) begin
      errors++; $display("FAIL b2b_data: busy=%b rd_data=%h required 0 a5a50002", busy, rd_data);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0 || bus_req_ !== 1'b1) begin
      errors++; $display("FAIL b2b_release: busy=%b req_=%b required 0 1", busy, bus_req_);
    end
    @(negedge clk);
  endtask

  task automatic test_store_delays();
    int busy_n = 0;
    int as_n = 0;
    bit done = 1'b0;
    mem_op = 2'd2; addr = 30'h0000_0100; wr_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 20; k++) begin
      bus_grnt_ = (k >= 4) ? 1'b0 : 1'b1;
      bus_rdy_ = (k >= 7) ? 1'b0 : 1'b1;
      #1;
      if (busy) busy_n++;
      if (!bus_as_) as_n++;
      if (k == 2) begin
        checks++;
        if (bus_rw !== 1'b0 || bus_wr_data !== 32'hDEAD_BEEF || bus_req_ !== 1'b0) begin
          errors++; $display("FAIL store_regs: rw=%b wd=%h req_=%b required 0 deadbeef 0", bus_rw, bus_wr_data, bus_req_);
        end
      end
      if (!busy) done = 1'b1;
      @(negedge clk);
      if (done) break;
    end
    idle_inputs();
    checks++;
    if (!done || busy_n != 7) begin
      errors++; $display("FAIL store_busy_cycles: got %0d done=%b required 7", busy_n, done);
    end
    checks++;
    if (as_n != 1) begin errors++; $display("FAIL store_as_pulse: got %0d cycles required 1", as_n); end
    @(negedge clk);
  endtask

  task automatic test_stall_hold();
    mem_op = 2'd1; addr = 30'h0000_0010; bus_grnt_ = 1'b0;
    @(negedge clk);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h1234_5678;
    @(negedge clk);
    stall = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_complete: rd_data=%h busy=%b required 12345678 0", rd_data, busy);
    end
    @(negedge clk);
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      stall = (k < 2);
      #1;
      checks++;
      if (rd_data !== 32'h1234_5678 || busy !== 1'b0 || bus_req_ !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d: rd_data=%h busy=%b req_=%b required 12345678 0 1", k, rd_data, busy, bus_req_);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++;
    if (rd_data !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_exit: rd_data=%h busy=%b required 0 0", rd_data, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    flush = 1'b1; mem_op = 2'd2; addr = 30'h0000_0200; wr_data = $urandom;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b required 0", busy); end
    @(negedge clk);
    #1;
    checks++;
    if (bus_req_ !== 1'b1) begin errors++; $display("FAIL flush_no_req: got %b required 1", bus_req_); end
    @(negedge clk);
    flush = 1'b0; mem_op = 2'd1; addr = 30'h0000_0030; bus_grnt_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || bus_as_ !== 1'b0) begin
      errors++; $display("FAIL flush_access_wait: busy=%b as_=%b required 1 0", busy, bus_as_);
    end
    @(negedge clk);
    bus_rdy_ = 1'b0; bus_rd_data = 32'h0BAD_F00D;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL flush_access_done: busy=%b rd_data=%h required 0 0badf00d", busy, rd_data);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus_req_ !== 1'b1) begin errors++; $display("FAIL flush_release: req_=%b required 1", bus_req_); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_op = 2'd1; addr = 30'h0000_0040;
    @(negedge clk);
    reset = 1'b1; mem_op = 2'd0;
    #1;
    checks++;
    if (bus_req_ !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: req_=%b busy=%b required 0 1", bus_req_, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_mid_post: req_=%b as_=%b busy=%b rd_data=%h required 1 1 0 0",
                         bus_req_, bus_as_, busy, rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit m_pend = 0, m_gnt = 0, m_first = 0, m_hold = 0, m_load = 0, m_rw = 1;
    logic [29:0] m_addr = '0;
    logic [31:0] m_wd = '0, m_hold_data = '0;
    bit act, spm, e_busy, e_spm_as, e_req, e_as, chk_rd;
    logic [31:0] e_rd;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 20);
      mem_op = 2'($urandom_range(0, 3));
      addr = {($urandom_range(0, 1) ? 3'h3 : 3'($urandom_range(0, 7))), 27'($urandom)};
      wr_data = $urandom; spm_rd_data = $urandom; bus_rd_data = $urandom;
      bus_grnt_ = 1'($urandom_range(0, 1)); bus_rdy_ = 1'($urandom_range(0, 1));
      act = !flush && (mem_op == 2'd1 || mem_op == 2'd2);
      spm = addr[29:27] == 3'h3;
      e_busy = 0; e_rd = '0; chk_rd = 1; e_spm_as = 1;
      e_req = !m_pend;
      e_as = !(m_pend && m_gnt && m_first);
      if (m_pend && !m_gnt) begin e_busy = 1; chk_rd = 0; end
      else if (m_pend && !bus_rdy_) begin e_rd = bus_rd_data; chk_rd = m_load; end
      else if (m_pend) begin e_busy = 1; chk_rd = 0; end
      else if (m_hold) begin e_rd = m_hold_data; chk_rd = m_load; end
      else if (act && spm) begin e_spm_as = 0; e_rd = spm_rd_data; chk_rd = (mem_op == 2'd1); end
      else if (act) begin e_busy = 1; chk_rd = 0; end
      #1;
      checks++;
      if (busy !== e_busy || bus_req_ !== e_req || bus_as_ !== e_as || spm_as_ !== e_spm_as) begin
        errors++; $display("FAIL rand_ctl[%0d]: busy=%b req_=%b as_=%b spm_as_=%b required %b %b %b %b",
                           i, busy, bus_req_, bus_as_, spm_as_, e_busy, e_req, e_as, e_spm_as);
      end
      checks++;
      if (bus_addr !== m_addr || bus_rw !== m_rw || bus_wr_data !== m_wd) begin
        errors++; $display("FAIL rand_bus_regs[%0d]: addr=%h rw=%b wd=%h required %h %b %h",
                           i, bus_addr, bus_rw, bus_wr_data, m_addr, m_rw, m_wd);
      end
      if (!e_spm_as) begin
        checks++;
        if (spm_rw !== (mem_op == 2'd1)) begin
          errors++; $display("FAIL rand_spm_rw[%0d]: got %b required %b", i, spm_rw, mem_op == 2'd1);
        end
      end
      if (chk_rd) begin
        checks++;
        if (rd_data !== e_rd) begin errors++; $display("FAIL rand_rd_data[%0d]: got %h required %h", i, rd_data, e_rd); end
      end
      if (reset) begin
        m_pend = 0; m_gnt = 0; m_first = 0; m_hold = 0; m_addr = '0; m_rw = 1; m_wd = '0;
      end else if (m_pend && !m_gnt) begin
        if (!bus_grnt_) begin m_gnt = 1; m_first = 1; end
      end else if (m_pend) begin
        m_first = 0;
        if (!bus_rdy_) begin m_pend = 0; m_hold = stall; m_hold_data = bus_rd_data; end
      end else if (m_hold) begin
        if (!stall) m_hold = 0;
      end else if (act && !spm) begin
        m_pend = 1; m_gnt = 0; m_addr = addr; m_rw = (mem_op == 2'd1); m_wd = wr_data; m_load = (mem_op == 2'd1);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_spm_load();
    test_back_to_back();
    test_store_delays();
    test_stall_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
